// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MDU_N = 32;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(MDU_N);

endpackage

// File: rtl/mdu_datapath.sv
// Shift-add multiplier / restoring divider on operand magnitudes, with the
// final sign fix-up and result selection.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         load,
  input  logic         step,
  input  op_e          op_i,
  input  logic [N-1:0] rs1_i,
  input  logic [N-1:0] rs2_i,
  output logic         special_o,
  output logic [N-1:0] special_res_o,
  output logic [N-1:0] fix_res_o
);

  function automatic logic [N-1:0] neg_n(input logic neg, input logic [N-1:0] x);
    return neg ? (~x + N'(1)) : x;
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic neg, input logic [2*N-1:0] x);
    return neg ? (~x + (2*N)'(1)) : x;
  endfunction

  op_e            op_q, op_d;
  logic           a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;  // multiplicand (shifting left) or divisor in low N bits
  logic [N-1:0]   opb_q, opb_d;      // multiplier (shifting right) or dividend becoming quotient
  logic [N-1:0]   rem_q, rem_d;

  logic           is_div, rs1_signed, rs2_signed, a_sgn, b_sgn;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     shifted, trial;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rmd;
  logic signed [N-1:0] rs1_s, rs2_s;

  always_comb begin
    is_div     = op_i[2];
    rs1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    rs2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_sgn      = rs1_signed && rs1_i[N-1];
    b_sgn      = rs2_signed && rs2_i[N-1];
    a_mag      = neg_n(a_sgn, rs1_i);
    b_mag      = neg_n(b_sgn, rs2_i);
    rs1_s      = rs1_i;
    rs2_s      = rs2_i;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    special_o     = 1'b0;
    special_res_o = '0;
    if (is_div && (rs2_i == '0)) begin
      special_o     = 1'b1;
      special_res_o = op_i[1] ? rs1_i : '1;
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (rs1_s == {1'b1, {(N-1){1'b0}}}) && (rs2_s == -1)) begin
      special_o     = 1'b1;
      special_res_o = op_i[1] ? '0 : rs1_i;
    end
  end

  always_comb begin
    op_d    = op_q;
    a_sgn_d = a_sgn_q;
    b_sgn_d = b_sgn_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    shifted = {rem_q, opb_q[N-1]};
    trial   = shifted - {1'b0, mcand_q[N-1:0]};
    if (load) begin
      op_d    = op_i;
      a_sgn_d = a_sgn;
      b_sgn_d = b_sgn;
      acc_d   = '0;
      mcand_d = {{N{1'b0}}, (is_div ? b_mag : a_mag)};
      opb_d   = is_div ? a_mag : b_mag;
      rem_d   = '0;
    end else if (step) begin
      if (op_q[2]) begin
        // Restoring step: keep the trial difference only when it did not borrow
        if (!trial[N]) begin
          rem_d = trial[N-1:0];
          opb_d = {opb_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          opb_d = {opb_q[N-2:0], 1'b0};
        end
      end else begin
        if (opb_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    a_sgn_q <= a_sgn_d;
    b_sgn_q <= b_sgn_d;
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    opb_q   <= opb_d;
    rem_q   <= rem_d;
  end

  always_comb begin
    prod = neg_2n(a_sgn_q ^ b_sgn_q, acc_q);
    quo  = neg_n(a_sgn_q ^ b_sgn_q, opb_q);
    rmd  = neg_n(a_sgn_q, rem_q);
    case (op_q)
      OP_MUL:                         fix_res_o = prod[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res_o = prod[2*N-1:N];
      OP_DIV, OP_DIVU:                fix_res_o = quo;
      OP_REM, OP_REMU:                fix_res_o = rmd;
      default:                        fix_res_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and the
// registered result/tag driving the destination register write port.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic [4:0]   rd_addr,
  output logic         busy,
  output logic         done,
  output logic         wr_en,
  output logic [N-1:0] result,
  output logic [4:0]   rd_tag
);

  localparam int CW = cnt_width(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic [4:0]     rd_tag_q, rd_tag_d;
  logic           load, step, special;
  logic [N-1:0]   special_res, fix_res;

  mdu_datapath #(.N(N)) u_datapath (
    .clk          (clk),
    .load         (load),
    .step         (step),
    .op_i         (op_e'(op)),
    .rs1_i        (rs1_data),
    .rs2_i        (rs2_data),
    .special_o    (special),
    .special_res_o(special_res),
    .fix_res_o    (fix_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_tag_d = rd_tag_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          rd_tag_d = rd_addr;
          cnt_d    = '0;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign wr_en  = done && (rd_tag_q != 5'd0);
  assign result = result_q;
  assign rd_tag = rd_tag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  rd_tag;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        wr;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned ncyc = 0;
  int          total = 0;
  int          bad = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  mul_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs1_data(rs1),
    .rs2_data(rs2),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .result  (result),
    .rd_tag  (rd_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result 0x%08h tag %0d want no done (cycle %0d)", result, rd_tag, ncyc);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_tag", {27'd0, rd_tag}, {27'd0, e.tag});
        chk("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
        chk("done_cycle", ncyc, e.cyc);
      end
    end else if (wr_en) begin
      total++;
      bad++;
      $display("FAIL wr_en_without_done: got 1 want 0 (cycle %0d)", ncyc);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] er, input int lat);
    exp_t e;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd_addr = rd; start = 1'b1;
    e.res = er; e.tag = rd; e.wr = (rd != 5'd0); e.cyc = ncyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_addr = 5'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: got %0d pending results want 0", sb.size());
    sb.delete();
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] er, input int lat);
    issue(o, a, b, rd, er, lat);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {27'd0, rd_tag}, 32'd0);
    reset = 1'b0;

    run(MUL,    32'd7,        32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 34);
    run(MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34);
    run(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34);
    run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34);
    run(DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 34);
    run(REM,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 34);
    run(DIVU,   32'd100,       32'd7,         5'd6,  32'd14,        34);
    run(REMU,   32'd100,       32'd7,         5'd7,  32'd2,         34);
    run(DIVU,   32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1);
    run(REM,    32'd5,         32'd0,         5'd10, 32'd5,         1);
    run(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run(REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);
    run(MUL,    32'd6,         32'd7,         5'd0,  32'd42,        34);

    // Back-to-back: second start in the cycle right after done
    issue(REMU, 32'd1000, 32'd33, 5'd13, 32'd10, 34);
    wait_idle();
    run(MULHU, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'd1, 34);

    // Start held while busy (including the done cycle) must be ignored
    issue(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      start = busy;
      op = MUL; rs1 = $urandom; rs2 = $urandom; rd_addr = 5'd31;
    end
    start = 1'b0;
    chk("busy_ignore_drained", sb.size(), 32'd0);

    // Reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = DIVU; rs1 = 32'd9; rs2 = 32'd3; rd_addr = 5'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    run(DIV, 32'd77, 32'd7, 5'd17, 32'd11, 34);

    // Reset in the middle of a DIV aborts it with no done pulse
    @(negedge clk);
    op = DIV; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; rd_addr = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_div_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_tag", {27'd0, rd_tag}, 32'd0);
    repeat (40) @(negedge clk);

    run(DIV, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFF2, 34);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
